// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU/MDU block: op codes, FSM states and
// XLEN-derived width helpers.
package alu_mdu_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_PASS2  = 6'd2;
  localparam logic [5:0] OP_ADDJ   = 6'd3;
  localparam logic [5:0] OP_SLL    = 6'd4;
  localparam logic [5:0] OP_SRL    = 6'd5;
  localparam logic [5:0] OP_SRA    = 6'd6;
  localparam logic [5:0] OP_SLT    = 6'd7;
  localparam logic [5:0] OP_SLTU   = 6'd8;
  localparam logic [5:0] OP_XOR    = 6'd9;
  localparam logic [5:0] OP_OR     = 6'd10;
  localparam logic [5:0] OP_AND    = 6'd11;
  localparam logic [5:0] OP_EQ     = 6'd12;
  localparam logic [5:0] OP_NE     = 6'd13;
  localparam logic [5:0] OP_LT     = 6'd14;
  localparam logic [5:0] OP_GE     = 6'd15;
  localparam logic [5:0] OP_LTU    = 6'd16;
  localparam logic [5:0] OP_GEU    = 6'd17;
  localparam logic [5:0] OP_MUL    = 6'd18;
  localparam logic [5:0] OP_MULH   = 6'd19;
  localparam logic [5:0] OP_MULHSU = 6'd20;
  localparam logic [5:0] OP_MULHU  = 6'd21;
  localparam logic [5:0] OP_DIV    = 6'd22;
  localparam logic [5:0] OP_DIVU   = 6'd23;
  localparam logic [5:0] OP_REM    = 6'd24;
  localparam logic [5:0] OP_REMU   = 6'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int shamt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  // One extra bit so the divider's fix-up step (count == XLEN) is representable.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) and restoring divide on operand magnitudes,
// with the sign correction applied when the final value is produced.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_run,
  input  logic            i_kill,
  input  logic [5:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = cnt_width(XLEN);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_want_hi;
  logic              r_want_rem;
  logic              r_neg;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;

  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_mul_hi;
  logic [XLEN-1:0]   w_mul_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_div_hi;
  logic [XLEN-1:0]   w_div_lo;

  assign w_sgn_a = i_src1[XLEN-1] && (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_sgn_b = i_src2[XLEN-1] && (i_op inside {OP_MULH, OP_DIV, OP_REM});
  assign w_mag_a = w_sgn_a ? -i_src1 : i_src1;
  assign w_mag_b = w_sgn_b ? -i_src2 : i_src2;

  // Multiply step: r_lo holds the unconsumed multiplier bits, product shifts in from the top.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_hi = w_sum[XLEN:1];
  assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
  assign w_prod   = {w_mul_hi, w_mul_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_opnd});
  assign w_diff   = w_shift[XLEN-1:0] - r_opnd;
  assign w_div_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_div_lo = {r_lo[XLEN-2:0], w_ge};

  assign o_last = r_is_div ? (r_cnt == CNT_W'(XLEN)) : (r_cnt == CNT_W'(XLEN - 1));

  // Final value: multiply uses the last step's output, divide fixes signs in its extra cycle.
  always_comb begin
    o_result = {XLEN{1'b0}};
    if (r_is_div) begin
      if (r_want_rem) begin
        o_result = r_neg_rem ? -r_hi : r_hi;
      end else begin
        o_result = r_neg ? -r_lo : r_lo;
      end
    end else begin
      o_result = r_want_hi ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];
    end
  end

  // Operand load on start, then one step per running cycle with a saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_is_div   <= 1'b0;
      r_want_hi  <= 1'b0;
      r_want_rem <= 1'b0;
      r_neg      <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= {XLEN{1'b0}};
      r_lo       <= {XLEN{1'b0}};
      r_opnd     <= {XLEN{1'b0}};
    end else if (i_start) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_is_div   <= is_div_op(i_op);
      r_want_hi  <= (i_op inside {OP_MULH, OP_MULHSU, OP_MULHU});
      r_want_rem <= (i_op inside {OP_REM, OP_REMU});
      r_neg      <= w_sgn_a ^ w_sgn_b;
      r_neg_rem  <= w_sgn_a;
      r_hi       <= {XLEN{1'b0}};
      r_lo       <= w_mag_a;
      r_opnd     <= w_mag_b;
    end else if (i_kill) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_run && (r_cnt != CNT_W'(XLEN))) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_is_div) begin
        r_hi <= w_div_hi;
        r_lo <= w_div_lo;
      end else begin
        r_hi <= w_mul_hi;
        r_lo <= w_mul_lo;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Integer ALU with single-cycle ops and an iterative multiply/divide unit,
// sequenced by an IDLE/BUSY/DONE handshake FSM.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = shamt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0]        r_result;
  logic [XLEN-1:0]        w_result_nxt;
  logic [XLEN-1:0]        w_alu_res;
  logic [XLEN-1:0]        w_mdu_res;
  logic [SHW-1:0]         w_shamt;
  logic signed [XLEN-1:0] w_s1;
  logic signed [XLEN-1:0] w_s2;
  logic                   w_div_zero;
  logic                   w_div_ovf;
  logic                   w_fast_div;
  logic                   w_iter_op;
  logic                   w_accept;
  logic                   w_mdu_start;
  logic                   w_mdu_run;
  logic                   w_mdu_last;

  assign w_shamt = src2[SHW-1:0];
  assign w_s1    = $signed(src1);
  assign w_s2    = $signed(src2);

  // Divide by zero and signed overflow bypass the iterative unit.
  assign w_div_zero  = (src2 == {XLEN{1'b0}});
  assign w_div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MIN_NEG) &&
                       (src2 == {XLEN{1'b1}});
  assign w_fast_div  = is_div_op(op) && (w_div_zero || w_div_ovf);
  assign w_iter_op   = is_mul_op(op) || (is_div_op(op) && !w_fast_div);
  assign w_accept    = (r_state == ST_IDLE) && in_valid && !kill;
  assign w_mdu_start = w_accept && w_iter_op;
  assign w_mdu_run   = (r_state == ST_BUSY) && !kill;

  // Single-cycle result, including the divide fast-path values.
  always_comb begin
    w_alu_res = {XLEN{1'b0}};
    case (op)
      OP_ADD:   w_alu_res = src1 + src2;
      OP_SUB:   w_alu_res = src1 - src2;
      OP_PASS2: w_alu_res = src2;
      OP_ADDJ:  w_alu_res = (src1 + src2) & {{(XLEN-1){1'b1}}, 1'b0};
      OP_SLL:   w_alu_res = src1 << w_shamt;
      OP_SRL:   w_alu_res = src1 >> w_shamt;
      OP_SRA:   w_alu_res = w_s1 >>> w_shamt;
      OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, (w_s1 < w_s2)};
      OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      OP_XOR:   w_alu_res = src1 ^ src2;
      OP_OR:    w_alu_res = src1 | src2;
      OP_AND:   w_alu_res = src1 & src2;
      OP_EQ:    w_alu_res = {{(XLEN-1){1'b0}}, (src1 == src2)};
      OP_NE:    w_alu_res = {{(XLEN-1){1'b0}}, (src1 != src2)};
      OP_LT:    w_alu_res = {{(XLEN-1){1'b0}}, (w_s1 < w_s2)};
      OP_GE:    w_alu_res = {{(XLEN-1){1'b0}}, (w_s1 >= w_s2)};
      OP_LTU:   w_alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      OP_GEU:   w_alu_res = {{(XLEN-1){1'b0}}, (src1 >= src2)};
      OP_DIV: begin
        if (w_div_zero) begin
          w_alu_res = {XLEN{1'b1}};
        end else if (w_div_ovf) begin
          w_alu_res = src1;
        end else begin
          w_alu_res = {XLEN{1'b0}};
        end
      end
      OP_DIVU:  w_alu_res = w_div_zero ? {XLEN{1'b1}} : {XLEN{1'b0}};
      OP_REM:   w_alu_res = w_div_zero ? src1 : {XLEN{1'b0}};
      OP_REMU:  w_alu_res = w_div_zero ? src1 : {XLEN{1'b0}};
      default:  w_alu_res = {XLEN{1'b0}};
    endcase
  end

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mdu_start),
    .i_run    (w_mdu_run),
    .i_kill   (kill),
    .i_op     (op),
    .i_src1   (src1),
    .i_src2   (src2),
    .o_last   (w_mdu_last),
    .o_result (w_mdu_res)
  );

  // Next state and result; kill wins over completion and over out_ready.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_iter_op) begin
          w_state_nxt = ST_BUSY;
        end else if (w_accept) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = w_alu_res;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (kill) begin
          w_state_nxt  = ST_IDLE;
          w_result_nxt = {XLEN{1'b0}};
        end else if (w_mdu_last) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = w_mdu_res;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (kill) begin
          w_state_nxt  = ST_IDLE;
          w_result_nxt = {XLEN{1'b0}};
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_result_nxt = {XLEN{1'b0}};
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= {XLEN{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_BUSY);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks;
  int n_errors;

  alu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_PASS2:  return b;
      OP_ADDJ:   return (a + b) & 32'hFFFF_FFFE;
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
      OP_SLT:    return {31'd0, sa < sb};
      OP_SLTU:   return {31'd0, a < b};
      OP_XOR:    return a ^ b;
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_EQ:     return {31'd0, a == b};
      OP_NE:     return {31'd0, a != b};
      OP_LT:     return {31'd0, sa < sb};
      OP_GE:     return {31'd0, sa >= sb};
      OP_LTU:    return {31'd0, a < b};
      OP_GEU:    return {31'd0, a >= b};
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb);
        return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with out_valid high.
  function automatic int ref_lat(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return 33;
    if (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (b == 32'd0) return 1;
      if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
    end
    return 1;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp     = ref_result(o, a, b);
    exp_lat = ref_lat(o, a, b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 6'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    if (exp_lat > 1) check_val({tag, "_busy"}, 64'(busy), 64'(1));
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_res"}, 64'(result), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hold"}, 64'({out_valid, in_ready, result}), 64'({2'b10, exp}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_ret"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    int         seen;
    logic [5:0] ro;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b0;
    op        = 6'd0;
    src1      = 32'd0;
    src2      = 32'd0;
    n_checks  = 0;
    n_errors  = 0;
    #2;
    check_val("rst_outs", 64'({out_valid, busy, result}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'(1));

    run_op(OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
    run_op(OP_SRA,   32'h8000_0000, 32'd31,        0, "sra31");
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run_op(OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, "div_m7_2");
    run_op(OP_REM,   32'hFFFF_FFF9, 32'd2,         0, "rem_m7_2");
    run_op(OP_DIVU,  32'd7,         32'd0,         0, "divu_z");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5, "div_ovf");
    run_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(OP_REMU,  32'd1234,      32'd0,         0, "remu_z");
    run_op(6'd40,    32'd5,         32'd6,         0, "unknown");

    // kill at cycle 10 of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; src1 = 32'd123; src2 = 32'd456;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_val("kill_busy", 64'({out_valid, busy, in_ready}), 64'(3'b001));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_val("kill_no_valid", 64'(seen), 64'(0));

    // kill coinciding with accept discards the request
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; op = OP_ADD; src1 = 32'd1; src2 = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0; kill = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk);
      #1;
    end
    check_val("kill_accept", 64'(seen), 64'(0));

    // kill together with out_ready in DONE
    @(negedge clk);
    in_valid = 1'b1; op = OP_XOR; src1 = 32'hF0F0_F0F0; src2 = 32'h0FF0_0FF0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("kd_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0; out_ready = 1'b0;
    check_val("kd_idle", 64'({out_valid, in_ready}), 64'(2'b01));

    // reset pulse in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_outs", 64'({out_valid, busy, result}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_mid_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_val("rst_mid_no_valid", 64'(seen), 64'(0));

    // randomized operations
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) ro = 6'($urandom_range(26, 63));
      else ro = 6'($urandom_range(0, 25));
      run_op(ro, pick_val(), pick_val(), int'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: XLEN, 32, datapath width; legal values 32 and 64.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  operation request.
REQ-005 Port: in_ready  output  1  block accepts request this cycle.
REQ-006 Port: op  input  6  operation code, values from shared package.
REQ-007 Port: src1  input  XLEN  operand 1.
REQ-008 Port: src2  input  XLEN  operand 2; shift amount is src2[log2(XLEN)-1:0].
REQ-009 Port: kill  input  1  abort in-flight operation (pipeline flush).
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: result  output  XLEN  operation result.
REQ-013 Port: busy  output  1  high in BUSY state.

Function
REQ-014 Ops SHALL be: ADD, SUB, PASS2 (lui), ADDJ ((src1+src2)&~1), SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND, EQ, NE, LT, GE, LTU, GEU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-015 Compare/branch ops SHALL return zero-extended 1-bit result in bit 0.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-017 Accept occurs on in_valid && in_ready; operands and op SHALL be captured on accept.
REQ-018 Non-M ops and unknown op codes SHALL go IDLE->DONE, out_valid one cycle after accept; unknown op result = 0.
REQ-019 MUL-class ops SHALL use iterative shift-add, one partial product per cycle, out_valid exactly XLEN+1 cycles after accept.
REQ-020 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-021 DIV-class ops SHALL use restoring division on magnitudes, sign fix-up in final cycle, out_valid exactly XLEN+2 cycles after accept.
REQ-022 Divide by zero: DIV/DIVU = all ones, REM/REMU = src1; SHALL take fast path, out_valid one cycle after accept.
REQ-023 Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV = src1, REM = 0; fast path, one-cycle latency.
REQ-024 DONE SHALL hold out_valid=1 and result stable until out_ready; on out_valid && out_ready state SHALL return to IDLE next cycle.
REQ-025 No new request SHALL be accepted in the cycle of out_ready handshake (in_ready low in DONE).
REQ-026 kill in BUSY or DONE SHALL return to IDLE next cycle, out_valid low, result discarded; kill in IDLE SHALL be ignored; kill coinciding with accept SHALL discard that request.
REQ-027 kill has priority over out_ready in the same cycle (no handshake counted).
REQ-028 Iteration counter SHALL be log2(XLEN)+1 bits and SHALL not wrap past its terminal count.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, out_valid=0, busy=0, result=0, counter=0.
REQ-030 Reset mid-BUSY SHALL abandon the operation with no out_valid after release.
REQ-031 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Structure
REQ-032 Package alu_mdu_pkg SHALL hold op-code constants, FSM state typedef, and XLEN-derived width helpers.
REQ-033 Iterative multiply/divide datapath SHALL be one sub-module, mdu_iter; single-cycle ops remain in alu_mdu.

Verification
REQ-034 ADD 0x7FFFFFFF+1 -> result 0x80000000, out_valid 1 cycle after accept; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-035 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE at cycle 33; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
REQ-036 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF at cycle 34; DIVU 7/0 -> 0xFFFFFFFF at cycle 1.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, cycle 1; out_ready held low 5 cycles -> result stable, in_ready low.
REQ-038 kill at cycle 10 of MUL -> out_valid never asserts, in_ready high next cycle; rst_n pulse mid-DIV -> IDLE, outputs 0.
